// File: rtl/psum_accumulator.sv
// psum_accumulator: adds the router's per-kernel partial sums across input-channel
// passes into a per-pixel accumulation buffer. On the final pass it emits every
// kernel's completed sum for one output pixel per transfer over valid/ready.
// Ports: clk/rst (async active-high); i_start + cfg_num_pixel/cfg_num_pass begin a job;
//   i_psum_kn0..3 (+_vld) carry the input beats; o_res/o_res_addr/o_res_vld/i_res_rdy
//   carry the results; o_busy, o_done and the sticky o_err_ovf report status.
module psum_accumulator #(
  parameter int BIT_WIDTH  = 8,
  parameter int NUM_KERNEL = 4,
  parameter int ACC_WIDTH  = 24,
  parameter int BUF_DEPTH  = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_start,
  input  logic [ADDR_WIDTH:0]              cfg_num_pixel,
  input  logic [7:0]                       cfg_num_pass,
  input  logic [2*BIT_WIDTH-1:0]           i_psum_kn0,
  input  logic [2*BIT_WIDTH-1:0]           i_psum_kn1,
  input  logic [2*BIT_WIDTH-1:0]           i_psum_kn2,
  input  logic [2*BIT_WIDTH-1:0]           i_psum_kn3,
  input  logic                             i_psum_kn0_vld,
  input  logic                             i_psum_kn1_vld,
  input  logic                             i_psum_kn2_vld,
  input  logic                             i_psum_kn3_vld,
  output logic [ACC_WIDTH*NUM_KERNEL-1:0]  o_res,
  output logic [ADDR_WIDTH-1:0]            o_res_addr,
  output logic                             o_res_vld,
  input  logic                             i_res_rdy,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_err_ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  // Configuration is held as "last index" values so the end-of-row and
  // end-of-job tests are plain equality compares against the counters.
  logic [ADDR_WIDTH-1:0] pix_last;
  logic [7:0]            pass_last;
  logic [ADDR_WIDTH-1:0] pix_cnt;
  logic [7:0]            pass_cnt;

  logic [ACC_WIDTH*NUM_KERNEL-1:0] acc_mem [BUF_DEPTH];
  logic [ACC_WIDTH*NUM_KERNEL-1:0] acc_old;
  logic [ACC_WIDTH*NUM_KERNEL-1:0] acc_new;
  logic [2*BIT_WIDTH-1:0]          psum [NUM_KERNEL];

  logic beat;
  logic last_pix;
  logic last_pass;
  logic load;

  assign psum[0] = i_psum_kn0;
  assign psum[1] = i_psum_kn1;
  assign psum[2] = i_psum_kn2;
  assign psum[3] = i_psum_kn3;

  assign beat      = (state == ACCUM) &&
                     i_psum_kn0_vld && i_psum_kn1_vld && i_psum_kn2_vld && i_psum_kn3_vld;
  assign last_pix  = (pix_cnt == pix_last);
  assign last_pass = (pass_cnt == pass_last);
  assign load      = beat && last_pass;

  // Combinational read-modify-write: the pixel counter moves every beat, and with a
  // single pixel the previous cycle's write has already landed before this read.
  assign acc_old = acc_mem[pix_cnt];

  always_comb begin
    acc_new = '0;
    for (int k = 0; k < NUM_KERNEL; k++) begin
      // Pass 0 starts from zero, so stale buffer contents never leak into a result.
      acc_new[k*ACC_WIDTH +: ACC_WIDTH] =
        ((pass_cnt == 8'd0) ? {ACC_WIDTH{1'b0}} : acc_old[k*ACC_WIDTH +: ACC_WIDTH]) +
        {{(ACC_WIDTH-2*BIT_WIDTH){psum[k][2*BIT_WIDTH-1]}}, psum[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (beat) begin
      acc_mem[pix_cnt] <= acc_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    o_busy    = 1'b1;
    o_done    = 1'b0;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (beat && last_pix && last_pass) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!o_res_vld || i_res_rdy) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_last  <= '0;
      pass_last <= '0;
      pix_cnt   <= '0;
      pass_cnt  <= '0;
    end else if (state == IDLE && i_start) begin
      // 0 means 1 for both sizes; pixel counts beyond the buffer are clamped to it.
      if (cfg_num_pixel == '0) begin
        pix_last <= '0;
      end else if (cfg_num_pixel > (ADDR_WIDTH+1)'(BUF_DEPTH)) begin
        pix_last <= ADDR_WIDTH'(BUF_DEPTH - 1);
      end else begin
        pix_last <= ADDR_WIDTH'(cfg_num_pixel - (ADDR_WIDTH+1)'(1));
      end
      pass_last <= (cfg_num_pass == 8'd0) ? 8'd0 : cfg_num_pass - 8'd1;
      pix_cnt   <= '0;
      pass_cnt  <= '0;
    end else if (beat) begin
      if (last_pix) begin
        pix_cnt  <= '0;
        pass_cnt <= pass_cnt + 8'd1;
      end else begin
        pix_cnt <= pix_cnt + ADDR_WIDTH'(1);
      end
    end
  end

  // Single output register: a new final-pass result that arrives while the held one
  // is still stalled is dropped (held result wins) and flagged in o_err_ovf.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_res      <= '0;
      o_res_addr <= '0;
      o_res_vld  <= 1'b0;
      o_err_ovf  <= 1'b0;
    end else if (load) begin
      if (o_res_vld && !i_res_rdy) begin
        o_err_ovf <= 1'b1;
      end else begin
        o_res      <= acc_new;
        o_res_addr <= pix_cnt;
        o_res_vld  <= 1'b1;
      end
    end else if (o_res_vld && i_res_rdy) begin
      o_res_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
`timescale 1ns/1ps
module tb_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [8:0]  cfg_num_pixel;
  logic [7:0]  cfg_num_pass;
  logic [15:0] tb_psum [4];
  logic        tb_vld [4];
  logic [95:0] o_res;
  logic [7:0]  o_res_addr;
  logic        o_res_vld;
  logic        i_res_rdy;
  logic        o_busy;
  logic        o_done;
  logic        o_err_ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_acc_cyc = 0;
  int          cap_addr[$];
  logic [95:0] cap_res[$];

  // Stimulus per job: stim[pass][pixel][kernel]
  logic [15:0] stim [4][256][4];

  psum_accumulator dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .cfg_num_pixel(cfg_num_pixel), .cfg_num_pass(cfg_num_pass),
    .i_psum_kn0(tb_psum[0]), .i_psum_kn1(tb_psum[1]),
    .i_psum_kn2(tb_psum[2]), .i_psum_kn3(tb_psum[3]),
    .i_psum_kn0_vld(tb_vld[0]), .i_psum_kn1_vld(tb_vld[1]),
    .i_psum_kn2_vld(tb_vld[2]), .i_psum_kn3_vld(tb_vld[3]),
    .o_res(o_res), .o_res_addr(o_res_addr), .o_res_vld(o_res_vld),
    .i_res_rdy(i_res_rdy), .o_busy(o_busy), .o_done(o_done), .o_err_ovf(o_err_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Observe accepted results and done pulses away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_res_vld && i_res_rdy) begin
        cap_addr.push_back(int'(o_res_addr));
        cap_res.push_back(o_res);
        last_acc_cyc = cyc;
      end
      if (o_done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
    tb_psum[0] = a; tb_psum[1] = b; tb_psum[2] = c; tb_psum[3] = d;
    for (int k = 0; k < 4; k++) tb_vld[k] = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) tb_vld[k] = 1'b0;
  endtask

  // A cycle where at least one valid is low: must never be consumed.
  task automatic drive_partial();
    logic [3:0] v;
    v = 4'($urandom_range(0, 14));
    for (int k = 0; k < 4; k++) begin
      tb_psum[k] = 16'($urandom);
      tb_vld[k]  = v[k];
    end
    tick();
    for (int k = 0; k < 4; k++) tb_vld[k] = 1'b0;
  endtask

  task automatic start_job(input int cp, input int cn);
    cfg_num_pixel = 9'(cp);
    cfg_num_pass  = 8'(cn);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (o_done) seen = 1'b1;
    end
    chk(tag, 128'(seen), 128'd1);
    tick();
  endtask

  task automatic fill_random(input int npix, input int npass);
    for (int p = 0; p < npass; p++)
      for (int x = 0; x < npix; x++)
        for (int k = 0; k < 4; k++) begin
          case ($urandom_range(0, 5))
            0: stim[p][x][k] = 16'h7FFF;
            1: stim[p][x][k] = 16'h8000;
            default: stim[p][x][k] = 16'($urandom);
          endcase
        end
  endtask

  // Reference: each kernel's result is the plain signed sum of its psums over all
  // passes for that pixel, reduced modulo 2^24.
  function automatic logic [95:0] model_sum(input int npass, input int x);
    logic [95:0] r;
    int s;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      s = 0;
      for (int p = 0; p < npass; p++) s += int'($signed(stim[p][x][k]));
      r[k*24 +: 24] = s[23:0];
    end
    return r;
  endfunction

  task automatic run_job(input string tag, input int npix, input int npass,
                         input int cp, input int cn, input bit gaps, input bit mid_start);
    int n;
    cap_addr.delete();
    cap_res.delete();
    done_cnt = 0;
    start_job(cp, cn);
    for (int p = 0; p < npass; p++) begin
      for (int x = 0; x < npix; x++) begin
        if (gaps && $urandom_range(0, 2) == 0) drive_partial();
        if (mid_start && p == 0 && x == 0) begin
          i_start = 1'b1;
          cfg_num_pixel = 9'd3;
          cfg_num_pass  = 8'd5;
        end
        drive_beat(stim[p][x][0], stim[p][x][1], stim[p][x][2], stim[p][x][3]);
        i_start = 1'b0;
      end
    end
    wait_done({tag, "_done"}, 50);
    tick();
    tick();
    chk({tag, "_count"}, 128'(cap_res.size()), 128'(npix));
    n = (cap_res.size() < npix) ? cap_res.size() : npix;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 128'(cap_addr[i]), 128'(i));
      chk($sformatf("%s_res%0d", tag, i), 128'(cap_res[i]), 128'(model_sum(npass, i)));
    end
    chk({tag, "_done_once"}, 128'(done_cnt), 128'd1);
    chk({tag, "_done_lat"}, 128'(done_cyc - last_acc_cyc), 128'd1);
    chk({tag, "_idle"}, 128'(o_busy), 128'd0);
  endtask

  initial begin
    rst = 1'b1;
    i_start = 1'b0;
    cfg_num_pixel = '0;
    cfg_num_pass = '0;
    i_res_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tb_psum[k] = '0;
      tb_vld[k]  = 1'b0;
    end
    repeat (2) tick();
    chk("rst_res", 128'(o_res), 128'd0);
    chk("rst_addr", 128'(o_res_addr), 128'd0);
    chk("rst_vld", 128'(o_res_vld), 128'd0);
    chk("rst_busy", 128'(o_busy), 128'd0);
    chk("rst_done", 128'(o_done), 128'd0);
    chk("rst_ovf", 128'(o_err_ovf), 128'd0);
    rst = 1'b0;
    tick();

    // Beats in IDLE are ignored.
    cap_res.delete();
    cap_addr.delete();
    drive_beat(16'd5, 16'd6, 16'd7, 16'd8);
    drive_beat(16'd1, 16'd1, 16'd1, 16'd1);
    tick();
    chk("idle_nocap", 128'(cap_res.size()), 128'd0);
    chk("idle_busy", 128'(o_busy), 128'd0);

    // Single pass, kn0 = 1..4.
    for (int x = 0; x < 4; x++)
      for (int k = 0; k < 4; k++) stim[0][x][k] = (k == 0) ? 16'(x + 1) : 16'd0;
    run_job("single", 4, 1, 4, 1, 1'b0, 1'b0);
    if (cap_res.size() == 4) chk("single_kn0_last", 128'(cap_res[3][23:0]), 128'd4);

    // Three passes, signed, on kn2.
    for (int p = 0; p < 3; p++)
      for (int x = 0; x < 2; x++)
        for (int k = 0; k < 4; k++) stim[p][x][k] = 16'd0;
    stim[0][0][2] = 16'd5;    stim[0][1][2] = 16'hFFFF;
    stim[1][0][2] = 16'd5;    stim[1][1][2] = 16'hFFFF;
    stim[2][0][2] = 16'h7FFF; stim[2][1][2] = 16'hFFFF;
    run_job("signed", 2, 3, 2, 3, 1'b1, 1'b0);
    if (cap_res.size() == 2) begin
      chk("signed_p0", 128'(cap_res[0][71:48]), 128'd32777);
      chk("signed_p1", 128'(cap_res[1][71:48]), 128'hFFFFFD);
    end

    // Partial valids and an i_start during ACCUM.
    fill_random(3, 2);
    run_job("midstart", 3, 2, 3, 2, 1'b1, 1'b1);

    // Zero config means one pixel, one pass.
    fill_random(1, 1);
    run_job("cfgzero", 1, 1, 0, 0, 1'b0, 1'b0);

    // Backpressure: second result dropped, first held.
    cap_res.delete();
    cap_addr.delete();
    done_cnt = 0;
    i_res_rdy = 1'b0;
    start_job(2, 1);
    drive_beat(16'd7, 16'd0, 16'd0, 16'd0);
    drive_beat(16'd9, 16'd0, 16'd0, 16'd0);
    @(negedge clk);
    chk("bp_vld", 128'(o_res_vld), 128'd1);
    chk("bp_res", 128'(o_res), 128'd7);
    chk("bp_addr", 128'(o_res_addr), 128'd0);
    chk("bp_ovf", 128'(o_err_ovf), 128'd1);
    repeat (3) @(negedge clk);
    chk("bp_no_done", 128'(done_cnt), 128'd0);
    chk("bp_busy", 128'(o_busy), 128'd1);
    tick();
    i_res_rdy = 1'b1;
    wait_done("bp_done", 20);
    tick();
    chk("bp_count", 128'(cap_res.size()), 128'd1);
    if (cap_res.size() > 0) chk("bp_cap", 128'(cap_res[0]), 128'd7);
    chk("bp_ovf_sticky", 128'(o_err_ovf), 128'd1);

    // Reset in pass 1 of 3 aborts asynchronously.
    fill_random(2, 3);
    done_cnt = 0;
    start_job(2, 3);
    drive_beat(stim[0][0][0], stim[0][0][1], stim[0][0][2], stim[0][0][3]);
    drive_beat(stim[0][1][0], stim[0][1][1], stim[0][1][2], stim[0][1][3]);
    drive_beat(stim[1][0][0], stim[1][0][1], stim[1][0][2], stim[1][0][3]);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 128'(o_busy), 128'd0);
    chk("arst_res", 128'(o_res), 128'd0);
    chk("arst_ovf", 128'(o_err_ovf), 128'd0);
    chk("arst_vld", 128'(o_res_vld), 128'd0);
    tick();
    rst = 1'b0;
    drive_beat(16'd3, 16'd3, 16'd3, 16'd3);
    tick();
    chk("arst_no_restart", 128'(o_busy), 128'd0);
    chk("arst_no_done", 128'(done_cnt), 128'd0);
    stim[0][0][0] = 16'd10; stim[1][0][0] = 16'd20;
    for (int k = 1; k < 4; k++) begin
      stim[0][0][k] = 16'($urandom);
      stim[1][0][k] = 16'($urandom);
    end
    run_job("post_rst", 1, 2, 1, 2, 1'b0, 1'b0);
    if (cap_res.size() == 1) chk("post_rst_30", 128'(cap_res[0][23:0]), 128'd30);

    // Wrap with a single pixel: read sees previous cycle's write.
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 4; k++) stim[p][0][k] = 16'h7FFF;
    run_job("wrap1", 1, 2, 1, 2, 1'b0, 1'b0);
    if (cap_res.size() == 1) chk("wrap1_val", 128'(cap_res[0]), 128'({4{24'h00FFFE}}));

    // Full buffer depth.
    fill_random(256, 2);
    run_job("full", 256, 2, 256, 2, 1'b0, 1'b0);
    if (cap_addr.size() == 256) chk("full_last_addr", 128'(cap_addr[255]), 128'd255);

    // Random jobs.
    for (int j = 0; j < 8; j++) begin
      int np, nq;
      np = $urandom_range(1, 8);
      nq = $urandom_range(1, 4);
      fill_random(np, nq);
      run_job($sformatf("rnd%0d", j), np, nq, np, nq, 1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
